// File: rtl/mem_arbiter_if.sv
// Bundles the two requester ports and the memory port of mem_arbiter.
// The slave modport is the arbiter's view; master is the core/RAM side.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  if_req_valid;
    logic                  if_req_ready;
    logic [31:0]           if_addr;
    logic                  if_resp_valid;
    logic [31:0]           if_resp_data;

    logic                  ls_req_valid;
    logic                  ls_req_ready;
    logic [31:0]           ls_addr;
    logic                  ls_we;
    logic [1:0]            ls_size;
    logic [31:0]           ls_wdata;
    logic                  ls_resp_valid;
    logic [31:0]           ls_resp_data;
    logic                  ls_resp_err;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport slave (
        input  if_req_valid, if_addr,
        output if_req_ready, if_resp_valid, if_resp_data,
        input  ls_req_valid, ls_addr, ls_we, ls_size, ls_wdata,
        output ls_req_ready, ls_resp_valid, ls_resp_data, ls_resp_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req_valid, if_addr,
        input  if_req_ready, if_resp_valid, if_resp_data,
        output ls_req_valid, ls_addr, ls_we, ls_size, ls_wdata,
        input  ls_req_ready, ls_resp_valid, ls_resp_data, ls_resp_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port word RAM between instruction fetch and load/store.
// Round-robin arbitration on ties; byte/half stores become read-modify-write
// so the RAM only ever sees whole-word accesses.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 10
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACCESS   = 3'd1,
        CAPTURE  = 3'd2,
        MERGE    = 3'd3,
        RESP_ERR = 3'd4
    } state_t;

    localparam logic       REQ_IF    = 1'b0;
    localparam logic       REQ_LS    = 1'b1;
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    state_t                state;
    logic                  last_grant;
    logic                  cur_req;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [1:0]            lane;
    logic [1:0]            size;
    logic                  we;
    logic [31:0]           wdata;

    logic                  if_resp_valid_q;
    logic [31:0]           if_resp_data_q;
    logic                  ls_resp_valid_q;
    logic [31:0]           ls_resp_data_q;
    logic                  ls_resp_err_q;

    logic                  grant_if;
    logic                  grant_ls;
    logic                  if_ready;
    logic                  ls_ready;
    logic                  ls_misaligned;
    logic [31:0]           merged;
    logic                  unused_addr_bits;

    // Address bits above the RAM depth are dropped so addresses wrap.
    assign unused_addr_bits = ^{bus.if_addr[31:ADDR_WIDTH+2], bus.ls_addr[31:ADDR_WIDTH+2]};

    // Pick a winner among valid requesters; on a tie the loser of the last grant wins.
    always_comb begin
        grant_if = bus.if_req_valid && (!bus.ls_req_valid || last_grant == REQ_LS);
        grant_ls = bus.ls_req_valid && (!bus.if_req_valid || last_grant == REQ_IF);
        if_ready = (state == IDLE) && !rst && grant_if;
        ls_ready = (state == IDLE) && !rst && grant_ls;
    end

    // Flag load/store requests whose size/alignment cannot be serviced.
    always_comb begin
        case (bus.ls_size)
            SIZE_BYTE: ls_misaligned = 1'b0;
            SIZE_HALF: ls_misaligned = bus.ls_addr[0];
            SIZE_WORD: ls_misaligned = |bus.ls_addr[1:0];
            default:   ls_misaligned = 1'b1;
        endcase
    end

    // Splice the store data into the word just read back from the RAM.
    always_comb begin
        merged = bus.mem_rdata;
        if (size == SIZE_BYTE) begin
            case (lane)
                2'd0: merged[7:0]   = wdata[7:0];
                2'd1: merged[15:8]  = wdata[7:0];
                2'd2: merged[23:16] = wdata[7:0];
                2'd3: merged[31:24] = wdata[7:0];
            endcase
        end else if (lane[1]) begin
            merged[31:16] = wdata[15:0];
        end else begin
            merged[15:0] = wdata[15:0];
        end
    end

    assign bus.if_req_ready  = if_ready;
    assign bus.ls_req_ready  = ls_ready;
    assign bus.if_resp_valid = if_resp_valid_q;
    assign bus.if_resp_data  = if_resp_data_q;
    assign bus.ls_resp_valid = ls_resp_valid_q;
    assign bus.ls_resp_data  = ls_resp_data_q;
    assign bus.ls_resp_err   = ls_resp_err_q;

    // RAM strobes are decoded from state so reset kills a pending write at once.
    assign bus.mem_en    = (state == ACCESS) || (state == MERGE);
    assign bus.mem_we    = ((state == ACCESS) && we && (size == SIZE_WORD)) || (state == MERGE);
    assign bus.mem_addr  = word_addr;
    assign bus.mem_wdata = (state == MERGE) ? merged : wdata;

    // Request sequencing: accept, access the RAM, then pulse the matching response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            last_grant      <= REQ_LS;
            cur_req         <= REQ_IF;
            word_addr       <= '0;
            lane            <= 2'd0;
            size            <= SIZE_WORD;
            we              <= 1'b0;
            wdata           <= 32'h0;
            if_resp_valid_q <= 1'b0;
            if_resp_data_q  <= 32'h0;
            ls_resp_valid_q <= 1'b0;
            ls_resp_data_q  <= 32'h0;
            ls_resp_err_q   <= 1'b0;
        end else begin
            if_resp_valid_q <= 1'b0;
            ls_resp_valid_q <= 1'b0;
            ls_resp_err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_ready) begin
                        cur_req    <= REQ_IF;
                        last_grant <= REQ_IF;
                        word_addr  <= bus.if_addr[ADDR_WIDTH+1:2];
                        lane       <= bus.if_addr[1:0];
                        size       <= SIZE_WORD;
                        we         <= 1'b0;
                        wdata      <= 32'h0;
                        state      <= ACCESS;
                    end else if (ls_ready) begin
                        cur_req    <= REQ_LS;
                        last_grant <= REQ_LS;
                        word_addr  <= bus.ls_addr[ADDR_WIDTH+1:2];
                        lane       <= bus.ls_addr[1:0];
                        size       <= bus.ls_size;
                        we         <= bus.ls_we;
                        wdata      <= bus.ls_wdata;
                        if (ls_misaligned) begin
                            ls_resp_valid_q <= 1'b1;
                            ls_resp_err_q   <= 1'b1;
                            ls_resp_data_q  <= 32'h0;
                            state           <= RESP_ERR;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (we && size == SIZE_WORD) begin
                        ls_resp_valid_q <= 1'b1;
                        ls_resp_data_q  <= 32'h0;
                        state           <= IDLE;
                    end else if (we) begin
                        state <= MERGE;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (cur_req == REQ_IF) begin
                        if_resp_valid_q <= 1'b1;
                        if_resp_data_q  <= bus.mem_rdata;
                    end else begin
                        ls_resp_valid_q <= 1'b1;
                        ls_resp_data_q  <= bus.mem_rdata;
                    end
                    state <= IDLE;
                end
                MERGE: begin
                    ls_resp_valid_q <= 1'b1;
                    ls_resp_data_q  <= 32'h0;
                    state           <= IDLE;
                end
                RESP_ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: RAM model, response scoreboard and
// one task per scenario.
module tb_mem_arbiter;
    localparam int ADDR_WIDTH = 10;

    logic        clk = 1'b0;
    logic        rst;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [31:0] exp_if_q [$];
    logic [32:0] exp_ls_q [$];

    mem_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();
    mem_arbiter #(.ADDR_WIDTH(ADDR_WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Synchronous RAM with a one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we === 1'b1) mem[bus.mem_addr] = bus.mem_wdata;
            else bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    // Pop the scoreboard whenever a response pulse appears.
    always @(negedge clk) begin
        logic [31:0] e;
        logic [32:0] el;
        if (bus.if_resp_valid === 1'b1) begin
            n_checks++;
            if (exp_if_q.size() == 0) $display("[TB] FAIL if_resp_unexpected: got %h required none", bus.if_resp_data);
            else begin
                e = exp_if_q.pop_front();
                if (bus.if_resp_data !== e) $display("[TB] FAIL if_resp_data: got %h required %h", bus.if_resp_data, e);
                else n_pass++;
            end
        end
        if (bus.ls_resp_valid === 1'b1) begin
            n_checks++;
            if (exp_ls_q.size() == 0) $display("[TB] FAIL ls_resp_unexpected: got err=%b data=%h required none", bus.ls_resp_err, bus.ls_resp_data);
            else begin
                el = exp_ls_q.pop_front();
                if ({bus.ls_resp_err, bus.ls_resp_data} !== el)
                    $display("[TB] FAIL ls_resp: got err=%b data=%h required err=%b data=%h", bus.ls_resp_err, bus.ls_resp_data, el[32], el[31:0]);
                else n_pass++;
            end
        end
    end

    task automatic issue_if(input logic [31:0] addr, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        bus.if_addr = addr;
        bus.if_req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.if_req_ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) begin @(posedge clk); #1; end
        bus.if_req_valid = 1'b0;
    endtask

    task automatic issue_ls(input logic [31:0] addr, input logic we, input logic [1:0] size,
                            input logic [31:0] wdata, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        bus.ls_addr = addr;
        bus.ls_we = we;
        bus.ls_size = size;
        bus.ls_wdata = wdata;
        bus.ls_req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.ls_req_ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) begin @(posedge clk); #1; end
        bus.ls_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.if_req_valid = 1'b1;
        bus.ls_req_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({bus.if_req_ready, bus.ls_req_ready} !== 2'b00) $display("[TB] FAIL reset_ready: got %b required 00", {bus.if_req_ready, bus.ls_req_ready});
        else n_pass++;
        n_checks++;
        if ({bus.if_resp_valid, bus.ls_resp_valid, bus.ls_resp_err, bus.mem_en, bus.mem_we} !== 5'b0)
            $display("[TB] FAIL reset_strobes: got %b required 00000", {bus.if_resp_valid, bus.ls_resp_valid, bus.ls_resp_err, bus.mem_en, bus.mem_we});
        else n_pass++;
        n_checks++;
        if ({bus.if_resp_data, bus.ls_resp_data, bus.mem_wdata, bus.mem_addr} !== '0)
            $display("[TB] FAIL reset_data: got %h %h %h %h required zeros", bus.if_resp_data, bus.ls_resp_data, bus.mem_wdata, bus.mem_addr);
        else n_pass++;
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        bit ok;
        mem[5] = 32'hDEADBEEF;
        exp_if_q.push_back(32'hDEADBEEF);
        issue_if(32'h14, ok);
        n_checks++;
        if (ok !== 1'b1) $display("[TB] FAIL fetch_handshake: got %b required 1", ok); else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 10'd5})
            $display("[TB] FAIL fetch_access: got en=%b we=%b addr=%0d required en=1 we=0 addr=5", bus.mem_en, bus.mem_we, bus.mem_addr);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.if_resp_valid !== 1'b0) $display("[TB] FAIL fetch_early_resp: got %b required 0", bus.if_resp_valid); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.if_resp_valid !== 1'b1) $display("[TB] FAIL fetch_resp_cycle3: got %b required 1", bus.if_resp_valid); else n_pass++;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] result;
    } sw_row_t;

    task automatic test_sub_word_store();
        bit ok;
        sw_row_t rows [5] = '{
            '{32'h09, 2'd0, 32'h000000AB, 32'h1122AB44},
            '{32'h0A, 2'd1, 32'h0000BEEF, 32'hBEEF3344},
            '{32'h08, 2'd1, 32'hFFFF5566, 32'h11225566},
            '{32'h0B, 2'd0, 32'h123456CD, 32'hCD223344},
            '{32'h08, 2'd0, 32'h00000077, 32'h11223377}
        };
        for (int r = 0; r < 5; r++) begin
            mem[2] = 32'h11223344;
            exp_ls_q.push_back({1'b0, 32'h0});
            issue_ls(rows[r].addr, 1'b1, rows[r].size, rows[r].wdata, ok);
            @(negedge clk);
            n_checks++;
            if ({ok, bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b1, 1'b0, 10'd2})
                $display("[TB] FAIL subword_read row%0d: got ok=%b en=%b we=%b addr=%0d required 1 1 0 2", r, ok, bus.mem_en, bus.mem_we, bus.mem_addr);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if ({bus.mem_en, bus.mem_we, bus.mem_wdata} !== {2'b11, rows[r].result})
                $display("[TB] FAIL subword_write row%0d: got en=%b we=%b wdata=%h required 1 1 %h", r, bus.mem_en, bus.mem_we, bus.mem_wdata, rows[r].result);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if ({bus.ls_resp_valid, mem[2]} !== {1'b1, rows[r].result})
                $display("[TB] FAIL subword_done row%0d: got resp=%b mem=%h required 1 %h", r, bus.ls_resp_valid, mem[2], rows[r].result);
            else n_pass++;
        end
    endtask

    task automatic test_word_store();
        bit ok;
        mem[4] = 32'h0;
        exp_ls_q.push_back({1'b0, 32'h0});
        issue_ls(32'h10, 1'b1, 2'd2, 32'hCAFEF00D, ok);
        @(negedge clk);
        n_checks++;
        if ({ok, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {3'b111, 10'd4, 32'hCAFEF00D})
            $display("[TB] FAIL word_store_write: got ok=%b en=%b we=%b addr=%0d wdata=%h required 1 1 1 4 cafef00d", ok, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({bus.ls_resp_valid, mem[4]} !== {1'b1, 32'hCAFEF00D})
            $display("[TB] FAIL word_store_done: got resp=%b mem=%h required 1 cafef00d", bus.ls_resp_valid, mem[4]);
        else n_pass++;
    endtask

    task automatic test_load();
        bit ok;
        logic [31:0] addrs [3] = '{32'h1C, 32'h1D, 32'h1E};
        logic [1:0]  sizes [3] = '{2'd2, 2'd0, 2'd1};
        mem[7] = 32'h0BADF00D;
        for (int r = 0; r < 3; r++) begin
            exp_ls_q.push_back({1'b0, 32'h0BADF00D});
            issue_ls(addrs[r], 1'b0, sizes[r], 32'hFFFFFFFF, ok);
            repeat (2) @(negedge clk);
            n_checks++;
            if ({ok, bus.ls_resp_valid} !== 2'b10) $display("[TB] FAIL load_cycle2 row%0d: got ok=%b resp=%b required 1 0", r, ok, bus.ls_resp_valid); else n_pass++;
            @(negedge clk);
            n_checks++;
            if (bus.ls_resp_valid !== 1'b1) $display("[TB] FAIL load_cycle3 row%0d: got %b required 1", r, bus.ls_resp_valid); else n_pass++;
        end
    endtask

    task automatic test_errors();
        bit ok;
        logic [31:0] addrs [4] = '{32'h06, 32'h04, 32'h03, 32'h05};
        logic        wes   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0]  sizes [4] = '{2'd2, 2'd3, 2'd1, 2'd3};
        mem[1] = 32'h55AA55AA;
        for (int r = 0; r < 4; r++) begin
            exp_ls_q.push_back({1'b1, 32'h0});
            issue_ls(addrs[r], wes[r], sizes[r], 32'h12345678, ok);
            @(negedge clk);
            n_checks++;
            if ({ok, bus.ls_resp_valid, bus.mem_en} !== 3'b110)
                $display("[TB] FAIL err_cycle1 row%0d: got ok=%b resp=%b en=%b required 1 1 0", r, ok, bus.ls_resp_valid, bus.mem_en);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if ({bus.ls_resp_valid, bus.mem_en} !== 2'b00)
                $display("[TB] FAIL err_cycle2 row%0d: got resp=%b en=%b required 0 0", r, bus.ls_resp_valid, bus.mem_en);
            else n_pass++;
        end
        n_checks++;
        if (mem[1] !== 32'h55AA55AA) $display("[TB] FAIL err_mem_unchanged: got %h required 55aa55aa", mem[1]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int second = -1;
        int n = 0;
        logic resp_at_second = 1'b0;
        mem[5] = 32'h13579BDF;
        @(negedge clk);
        bus.if_addr = 32'h14;
        bus.if_req_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.if_req_ready === 1'b1) begin
                exp_if_q.push_back(32'h13579BDF);
                if (n == 0) first = c;
                else begin second = c; resp_at_second = bus.if_resp_valid; end
                n++;
                if (n == 2) begin @(posedge clk); #1; break; end
            end
            @(negedge clk);
        end
        bus.if_req_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (second - first !== 3) $display("[TB] FAIL b2b_spacing: got %0d required 3", second - first); else n_pass++;
        n_checks++;
        if (resp_at_second !== 1'b1) $display("[TB] FAIL b2b_overlap: got %b required 1", resp_at_second); else n_pass++;
    endtask

    task automatic test_contention();
        logic [3:0] seq = 4'b0;
        int n = 0;
        bit both = 1'b0;
        mem[8] = 32'h80808080;
        mem[9] = 32'h90909090;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.if_addr = 32'h20;
        bus.ls_addr = 32'h24;
        bus.ls_we = 1'b0;
        bus.ls_size = 2'd2;
        bus.if_req_valid = 1'b1;
        bus.ls_req_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus.if_req_ready === 1'b1 && bus.ls_req_ready === 1'b1) both = 1'b1;
            if (bus.if_req_ready === 1'b1) begin
                exp_if_q.push_back(32'h80808080);
                seq[n] = 1'b0;
                n++;
            end else if (bus.ls_req_ready === 1'b1) begin
                exp_ls_q.push_back({1'b0, 32'h90909090});
                seq[n] = 1'b1;
                n++;
            end
            if (n == 4) begin @(posedge clk); #1; break; end
            @(negedge clk);
        end
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({n[2:0], seq} !== {3'd4, 4'b1010}) $display("[TB] FAIL contention_order: got n=%0d seq=%b required n=4 seq=1010", n, seq); else n_pass++;
        n_checks++;
        if (both !== 1'b0) $display("[TB] FAIL contention_two_readies: got %b required 0", both); else n_pass++;
    endtask

    task automatic test_wrap();
        bit ok;
        logic [31:0] addrs [3] = '{32'h1000, 32'h0000, 32'hFFFFF000};
        mem[0] = 32'h0F0F0F0F;
        for (int r = 0; r < 3; r++) begin
            exp_ls_q.push_back({1'b0, 32'h0F0F0F0F});
            issue_ls(addrs[r], 1'b0, 2'd2, 32'h0, ok);
            @(negedge clk);
            n_checks++;
            if ({ok, bus.mem_en, bus.mem_addr} !== {2'b11, 10'd0})
                $display("[TB] FAIL wrap_addr row%0d: got ok=%b en=%b addr=%0d required 1 1 0", r, ok, bus.mem_en, bus.mem_addr);
            else n_pass++;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        mem[3] = 32'h01020304;
        issue_ls(32'h0C, 1'b1, 2'd0, 32'hFF, ok);
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ok, bus.mem_en, bus.mem_we, bus.mem_wdata} !== {3'b111, 32'h010203FF})
            $display("[TB] FAIL rstmid_merge: got ok=%b en=%b we=%b wdata=%h required 1 1 1 010203ff", ok, bus.mem_en, bus.mem_we, bus.mem_wdata);
        else n_pass++;
        #1;
        rst = 1'b1;
        bus.if_req_valid = 1'b1;
        bus.ls_req_valid = 1'b1;
        #1;
        n_checks++;
        if ({bus.mem_en, bus.mem_we, bus.if_req_ready, bus.ls_req_ready, bus.if_resp_valid, bus.ls_resp_valid} !== 6'b0)
            $display("[TB] FAIL rstmid_outputs: got %b required 000000", {bus.mem_en, bus.mem_we, bus.if_req_ready, bus.ls_req_ready, bus.if_resp_valid, bus.ls_resp_valid});
        else n_pass++;
        n_checks++;
        if ({bus.if_resp_data, bus.ls_resp_data} !== 64'h0)
            $display("[TB] FAIL rstmid_resp_data: got %h %h required 0 0", bus.if_resp_data, bus.ls_resp_data);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (mem[3] !== 32'h01020304) $display("[TB] FAIL rstmid_mem: got %h required 01020304", mem[3]); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.if_req_ready, bus.ls_req_ready} !== 2'b10)
            $display("[TB] FAIL rstmid_tie: got %b required 10", {bus.if_req_ready, bus.ls_req_ready});
        else n_pass++;
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;
        #1;
        n_checks++;
        if ({bus.if_req_ready, bus.ls_req_ready} !== 2'b00)
            $display("[TB] FAIL release_ready: got %b required 00", {bus.if_req_ready, bus.ls_req_ready});
        else n_pass++;
        repeat (5) @(negedge clk);
    endtask

    // Scenario sequence, followed by a check that every expected response arrived.
    initial begin
        bus.if_req_valid = 1'b0;
        bus.if_addr = 32'h0;
        bus.ls_req_valid = 1'b0;
        bus.ls_addr = 32'h0;
        bus.ls_we = 1'b0;
        bus.ls_size = 2'd0;
        bus.ls_wdata = 32'h0;
        for (int i = 0; i < (1 << ADDR_WIDTH); i++) mem[i] = 32'h0;
        test_reset();
        test_fetch();
        test_sub_word_store();
        test_word_store();
        test_load();
        test_errors();
        test_back_to_back();
        test_contention();
        test_wrap();
        test_reset_mid();
        n_checks++;
        if (exp_if_q.size() != 0 || exp_ls_q.size() != 0)
            $display("[TB] FAIL scoreboard_drained: got if=%0d ls=%0d outstanding required 0 0", exp_if_q.size(), exp_ls_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
